// File: rtl/bht_update_sched_if.sv
// Update-request and BHT RAM port bundle for bht_update_sched.
// master = scheduler side, slave = EXECUTE/FTQ and RAM side.
interface bht_update_sched_if #(
    parameter int IDX_W = 9,
    parameter int ROW_W = 1,
    parameter int IPF   = 2,
    parameter int EW    = 3
);
    logic                upd_valid_i;
    logic [IDX_W-1:0]    upd_index_i;
    logic [ROW_W-1:0]    upd_row_i;
    logic                upd_taken_i;
    logic                ram_re_o;
    logic                ram_gnt_i;
    logic [IDX_W-1:0]    ram_raddr_o;
    logic [IPF*EW-1:0]   ram_rdata_i;
    logic [IPF-1:0]      ram_we_o;
    logic [IDX_W-1:0]    ram_waddr_o;
    logic [IPF*EW-1:0]   ram_wdata_o;

    modport master (
        input  upd_valid_i, upd_index_i, upd_row_i, upd_taken_i, ram_gnt_i, ram_rdata_i,
        output ram_re_o, ram_raddr_o, ram_we_o, ram_waddr_o, ram_wdata_o
    );
    modport slave (
        output upd_valid_i, upd_index_i, upd_row_i, upd_taken_i, ram_gnt_i, ram_rdata_i,
        input  ram_re_o, ram_raddr_o, ram_we_o, ram_waddr_o, ram_wdata_o
    );
endinterface

// File: rtl/bht_update_sched.sv
// Write sequencer for a RAM-based bimodal BHT: init/flush walk plus queued read-modify-write updates.
// Optional BHT_SCHED_PERF_EN adds saturating commit/drop counters.
//
// state | meaning
// WALK  | writing {0,CTR_INIT} to every row, predictions invalid
// RUN   | draining the update FIFO through the shared read port
module bht_update_sched #(
    parameter int unsigned         NR_ROWS         = 512,
    parameter int unsigned         INSTR_PER_FETCH = 2,
    parameter int unsigned         CTR_BITS        = 2,
    parameter logic [CTR_BITS-1:0] CTR_INIT        = 2'b10,
    parameter int unsigned         FIFO_DEPTH      = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_bp_i,
    input  logic debug_mode_i,
    bht_update_sched_if.master bus,
    output logic busy_o,
    output logic drop_o
`ifdef BHT_SCHED_PERF_EN
    ,
    output logic [31:0] upd_cnt_o,
    output logic [31:0] drop_cnt_o
`endif
);
    localparam int IDX_W = $clog2(NR_ROWS);
    localparam int ROW_W = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;
    localparam int EW    = CTR_BITS + 1;
    localparam int IPF   = INSTR_PER_FETCH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [IDX_W-1:0]    LAST_ROW = IDX_W'(NR_ROWS - 1);
    localparam logic [PTR_W:0]      FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [0:0]          STATE_WALK = 1'b0;
    localparam logic [0:0]          STATE_RUN  = 1'b1;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [ROW_W-1:0] row;
        logic             taken;
    } upd_t;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] walk_cnt_q, walk_cnt_d;
    upd_t             fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             s1_v_q;
    upd_t             s1_q;
    logic             lw_v_q;
    logic [IDX_W-1:0] lw_idx_q;
    logic [ROW_W-1:0] lw_row_q;
    logic [CTR_BITS-1:0] lw_ctr_q;
    logic             drop_q, drop_d;

    logic is_run, fifo_empty, fifo_full, issue, pop, upd_req, push, wr_upd, fwd_hit;
    logic [CTR_BITS-1:0] ram_ctr, old_ctr, new_ctr;

    assign is_run     = (state_q == STATE_RUN);
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FULL_CNT);
    assign issue      = !rst_i && is_run && !flush_bp_i && !fifo_empty;
    assign pop        = issue && bus.ram_gnt_i;
    assign upd_req    = !rst_i && is_run && !flush_bp_i && bus.upd_valid_i && !debug_mode_i;
    assign push       = upd_req && (!fifo_full || pop);
    assign drop_d     = upd_req && fifo_full && !pop;
    assign wr_upd     = !rst_i && !flush_bp_i && s1_v_q;

    // RAM returns the pre-write value on a same-cycle collision, so the last write is forwarded.
    assign fwd_hit = lw_v_q && (lw_idx_q == s1_q.idx) && (lw_row_q == s1_q.row);

    always_comb begin
        ram_ctr = '0;
        for (int i = 0; i < IPF; i++) begin
            if (s1_q.row == ROW_W'(i)) ram_ctr = bus.ram_rdata_i[i*EW +: CTR_BITS];
        end
        old_ctr = fwd_hit ? lw_ctr_q : ram_ctr;
        new_ctr = old_ctr;
        if (s1_q.taken && old_ctr != CTR_MAX)     new_ctr = old_ctr + 1'b1;
        else if (!s1_q.taken && old_ctr != '0)    new_ctr = old_ctr - 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        walk_cnt_d = walk_cnt_q;
        if (flush_bp_i) begin
            state_d    = STATE_WALK;
            walk_cnt_d = '0;
        end else if (state_q == STATE_WALK) begin
            walk_cnt_d = walk_cnt_q + 1'b1;
            if (walk_cnt_q == LAST_ROW) state_d = STATE_RUN;
        end
    end

    always_comb begin
        bus.ram_re_o    = 1'b0;
        bus.ram_raddr_o = '0;
        bus.ram_we_o    = '0;
        bus.ram_waddr_o = '0;
        bus.ram_wdata_o = '0;
        busy_o          = 1'b0;
        if (!rst_i) begin
            if (state_q == STATE_WALK) begin
                bus.ram_we_o    = '1;
                bus.ram_waddr_o = walk_cnt_q;
                bus.ram_wdata_o = {IPF{{1'b0, CTR_INIT}}};
                busy_o          = 1'b1;
            end else if (wr_upd) begin
                bus.ram_waddr_o = s1_q.idx;
                for (int i = 0; i < IPF; i++) begin
                    if (s1_q.row == ROW_W'(i)) begin
                        bus.ram_we_o[i]             = 1'b1;
                        bus.ram_wdata_o[i*EW +: EW] = {1'b1, new_ctr};
                    end
                end
            end
            if (issue) begin
                bus.ram_re_o    = 1'b1;
                bus.ram_raddr_o = fifo_q[rd_ptr_q].idx;
            end
        end
    end

    assign drop_o = drop_q && !rst_i;

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= '{idx: bus.upd_index_i, row: bus.upd_row_i, taken: bus.upd_taken_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= STATE_WALK;
            walk_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            s1_v_q     <= 1'b0;
            s1_q       <= '0;
            lw_v_q     <= 1'b0;
            lw_idx_q   <= '0;
            lw_row_q   <= '0;
            lw_ctr_q   <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            walk_cnt_q <= walk_cnt_d;
            drop_q     <= drop_d;
            if (flush_bp_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                cnt_q    <= '0;
                s1_v_q   <= 1'b0;
                lw_v_q   <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                if (push && !pop)      cnt_q <= cnt_q + 1'b1;
                else if (pop && !push) cnt_q <= cnt_q - 1'b1;
                s1_v_q <= pop;
                if (pop) s1_q <= fifo_q[rd_ptr_q];
                if (wr_upd) begin
                    lw_v_q   <= 1'b1;
                    lw_idx_q <= s1_q.idx;
                    lw_row_q <= s1_q.row;
                    lw_ctr_q <= new_ctr;
                end
            end
        end
    end

`ifdef BHT_SCHED_PERF_EN
    logic [31:0] upd_cnt_q, drop_cnt_q;

    // Survives flush; only reset clears the counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            upd_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (wr_upd && upd_cnt_q != '1)   upd_cnt_q  <= upd_cnt_q + 1'b1;
            if (drop_d && drop_cnt_q != '1)  drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign upd_cnt_o  = upd_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
`endif
endmodule

// File: tb/tb_bht_update_sched.sv
// Directed bench for bht_update_sched with a 16-row BHT, two entries per row.
module tb_bht_update_sched;
    localparam int IDX_W = 4;
    localparam int ROW_W = 1;
    localparam int IPF   = 2;
    localparam int EW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic dbg = 1'b0;
    logic busy, drop;
    int   n_cmp = 0;
    int   n_err = 0;

    bht_update_sched_if #(.IDX_W(IDX_W), .ROW_W(ROW_W), .IPF(IPF), .EW(EW)) bus ();

`ifdef BHT_SCHED_PERF_EN
    logic [31:0] upd_cnt, drop_cnt;
`endif

    bht_update_sched #(
        .NR_ROWS(16), .INSTR_PER_FETCH(2), .CTR_BITS(2), .CTR_INIT(2'b10), .FIFO_DEPTH(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .flush_bp_i(flush),
        .debug_mode_i(dbg),
        .bus(bus),
        .busy_o(busy),
        .drop_o(drop)
`ifdef BHT_SCHED_PERF_EN
        ,
        .upd_cnt_o(upd_cnt),
        .drop_cnt_o(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Advance to the next cycle; inputs are then set and outputs sampled mid-cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic v, input logic [3:0] idx, input logic row, input logic tk);
        bus.upd_valid_i = v;
        bus.upd_index_i = idx;
        bus.upd_row_i   = row;
        bus.upd_taken_i = tk;
    endtask

    task automatic test_reset();
        next_cycle();
        rst = 1'b1;
        set_upd(1'b1, 4'd3, 1'b0, 1'b1);
        #1;
        n_cmp++;
        if ({bus.ram_we_o, bus.ram_re_o, busy, drop} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got we=%b re=%b busy=%b drop=%b want all 0",
                     bus.ram_we_o, bus.ram_re_o, busy, drop);
        end
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            #1;
            n_cmp++;
            if (bus.ram_we_o !== 2'b11 || bus.ram_waddr_o !== 4'(k) || bus.ram_wdata_o !== 6'b010_010 ||
                busy !== 1'b1 || bus.ram_re_o !== 1'b0 || drop !== 1'b0) begin
                n_err++;
                $display("FAIL walk_row%0d: got we=%b waddr=%0d wdata=%b busy=%b re=%b drop=%b want 11/%0d/010010/1/0/0",
                         k, bus.ram_we_o, bus.ram_waddr_o, bus.ram_wdata_o, busy, bus.ram_re_o, drop, k);
            end
            next_cycle();
        end
        set_upd(1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || bus.ram_we_o !== 2'b00 || bus.ram_re_o !== 1'b0) begin
            n_err++;
            $display("FAIL walk_end: got busy=%b we=%b re=%b want 0/00/0", busy, bus.ram_we_o, bus.ram_re_o);
        end
    endtask

    task automatic test_taken_inc();
        bus.ram_gnt_i   = 1'b1;
        bus.ram_rdata_i = 6'b110_100;
        next_cycle();
        set_upd(1'b1, 4'd5, 1'b1, 1'b1);
        next_cycle();
        set_upd(1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (bus.ram_re_o !== 1'b1 || bus.ram_raddr_o !== 4'd5 || bus.ram_we_o !== 2'b00) begin
            n_err++;
            $display("FAIL t2_issue: got re=%b raddr=%0d we=%b want 1/5/00", bus.ram_re_o, bus.ram_raddr_o, bus.ram_we_o);
        end
        next_cycle();
        #1;
        n_cmp++;
        if (bus.ram_we_o !== 2'b10 || bus.ram_waddr_o !== 4'd5 || bus.ram_wdata_o !== 6'b111_000) begin
            n_err++;
            $display("FAIL t2_write: got we=%b waddr=%0d wdata=%b want 10/5/111000",
                     bus.ram_we_o, bus.ram_waddr_o, bus.ram_wdata_o);
        end
        next_cycle();
        #1;
        n_cmp++;
        if (bus.ram_we_o !== 2'b00 || bus.ram_re_o !== 1'b0) begin
            n_err++;
            $display("FAIL t2_idle: got we=%b re=%b want 00/0", bus.ram_we_o, bus.ram_re_o);
        end
    endtask

    task automatic test_saturate();
        logic [3:0] idx_t [3]   = '{4'd3, 4'd9, 4'd2};
        logic       row_t [3]   = '{1'b0, 1'b1, 1'b1};
        logic       tk_t  [3]   = '{1'b1, 1'b0, 1'b0};
        logic [5:0] rd_t  [3]   = '{6'b000_111, 6'b100_000, 6'b110_000};
        logic [1:0] we_t  [3]   = '{2'b01, 2'b10, 2'b10};
        logic [5:0] wd_t  [3]   = '{6'b000_111, 6'b100_000, 6'b101_000};
        for (int n = 0; n < 3; n++) begin
            next_cycle();
            bus.ram_rdata_i = rd_t[n];
            set_upd(1'b1, idx_t[n], row_t[n], tk_t[n]);
            next_cycle();
            set_upd(1'b0, 4'd0, 1'b0, 1'b0);
            next_cycle();
            #1;
            n_cmp++;
            if (bus.ram_we_o !== we_t[n] || bus.ram_waddr_o !== idx_t[n] || bus.ram_wdata_o !== wd_t[n]) begin
                n_err++;
                $display("FAIL t3_case%0d: got we=%b waddr=%0d wdata=%b want %b/%0d/%b",
                         n, bus.ram_we_o, bus.ram_waddr_o, bus.ram_wdata_o, we_t[n], idx_t[n], wd_t[n]);
            end
        end
    endtask

    task automatic test_forwarding();
        logic [5:0] wd_t [3] = '{6'b000_110, 6'b000_111, 6'b000_111};
        bus.ram_rdata_i = 6'b000_101;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            if (c < 3) set_upd(1'b1, 4'd5, 1'b0, 1'b1);
            else       set_upd(1'b0, 4'd0, 1'b0, 1'b0);
            #1;
            if (c >= 2 && c <= 4) begin
                n_cmp++;
                if (bus.ram_we_o !== 2'b01 || bus.ram_waddr_o !== 4'd5 || bus.ram_wdata_o !== wd_t[c-2]) begin
                    n_err++;
                    $display("FAIL t4_write%0d: got we=%b waddr=%0d wdata=%b want 01/5/%b",
                             c - 2, bus.ram_we_o, bus.ram_waddr_o, bus.ram_wdata_o, wd_t[c-2]);
                end
            end else if (c == 5) begin
                n_cmp++;
                if (bus.ram_we_o !== 2'b00) begin
                    n_err++;
                    $display("FAIL t4_idle: got we=%b want 00", bus.ram_we_o);
                end
            end
        end
    endtask

    task automatic test_drop();
        logic [3:0] ids [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7};
        logic       exp_re, exp_drop;
        logic [3:0] exp_raddr;
        logic [1:0] exp_we;
        logic [5:0] exp_wd;
        bus.ram_rdata_i = 6'b101_101;
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            bus.ram_gnt_i = (c >= 6);
            if (c < 6) set_upd(1'b1, ids[c], 1'(c), 1'b1);
            else       set_upd(1'b0, 4'd0, 1'b0, 1'b0);
            exp_re    = (c >= 1 && c <= 9);
            exp_raddr = exp_re ? ((c <= 6) ? ids[0] : ids[c-6]) : 4'd0;
            exp_drop  = (c == 5 || c == 6);
            exp_we    = 2'b00;
            exp_wd    = 6'b000_000;
            if (c >= 7 && c <= 10) begin
                exp_we = (c[0] == 1'b1) ? 2'b01 : 2'b10;
                exp_wd = (c[0] == 1'b1) ? 6'b000_110 : 6'b110_000;
            end
            #1;
            n_cmp++;
            if (bus.ram_re_o !== exp_re || (exp_re && bus.ram_raddr_o !== exp_raddr) || drop !== exp_drop ||
                bus.ram_we_o !== exp_we || (exp_we != 2'b00 && (bus.ram_waddr_o !== ids[c-7] || bus.ram_wdata_o !== exp_wd))) begin
                n_err++;
                $display("FAIL t5_cycle%0d: got re=%b raddr=%0d drop=%b we=%b waddr=%0d wdata=%b want re=%b raddr=%0d drop=%b we=%b wdata=%b",
                         c, bus.ram_re_o, bus.ram_raddr_o, drop, bus.ram_we_o, bus.ram_waddr_o, bus.ram_wdata_o,
                         exp_re, exp_raddr, exp_drop, exp_we, exp_wd);
            end
        end
    endtask

    task automatic test_debug();
        next_cycle();
        dbg = 1'b1;
        bus.ram_gnt_i = 1'b1;
        set_upd(1'b1, 4'd8, 1'b0, 1'b1);
        next_cycle();
        set_upd(1'b0, 4'd0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (bus.ram_re_o !== 1'b0 || bus.ram_we_o !== 2'b00 || drop !== 1'b0) begin
                n_err++;
                $display("FAIL debug_block%0d: got re=%b we=%b drop=%b want 0/00/0", c, bus.ram_re_o, bus.ram_we_o, drop);
            end
            next_cycle();
        end
        dbg = 1'b0;
    endtask

    task automatic test_flush();
        bus.ram_gnt_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            set_upd(1'b1, 4'(10 + c), 1'b0, 1'b1);
        end
        next_cycle();
        set_upd(1'b0, 4'd0, 1'b0, 1'b0);
        bus.ram_gnt_i = 1'b1;
        flush = 1'b1;
        #1;
        n_cmp++;
        if (bus.ram_re_o !== 1'b0 || bus.ram_we_o !== 2'b00) begin
            n_err++;
            $display("FAIL flush_cycle: got re=%b we=%b want 0/00", bus.ram_re_o, bus.ram_we_o);
        end
        next_cycle();
        flush = 1'b0;
        // Partial walk, then a second flush must restart it from row 0.
        for (int k = 0; k < 6; k++) begin
            if (k == 5) flush = 1'b1;
            #1;
            n_cmp++;
            if (bus.ram_we_o !== 2'b11 || bus.ram_waddr_o !== 4'(k) || busy !== 1'b1) begin
                n_err++;
                $display("FAIL flush_walk_a%0d: got we=%b waddr=%0d busy=%b want 11/%0d/1", k, bus.ram_we_o, bus.ram_waddr_o, busy, k);
            end
            next_cycle();
        end
        flush = 1'b0;
        for (int k = 0; k < 16; k++) begin
            #1;
            n_cmp++;
            if (bus.ram_we_o !== 2'b11 || bus.ram_waddr_o !== 4'(k) || bus.ram_wdata_o !== 6'b010_010 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL flush_walk_b%0d: got we=%b waddr=%0d wdata=%b busy=%b want 11/%0d/010010/1",
                         k, bus.ram_we_o, bus.ram_waddr_o, bus.ram_wdata_o, busy, k);
            end
            next_cycle();
        end
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (busy !== 1'b0 || bus.ram_re_o !== 1'b0 || bus.ram_we_o !== 2'b00) begin
                n_err++;
                $display("FAIL flush_after%0d: got busy=%b re=%b we=%b want 0/0/00", c, busy, bus.ram_re_o, bus.ram_we_o);
            end
            next_cycle();
        end
    endtask

    initial begin
        bus.ram_gnt_i   = 1'b0;
        bus.ram_rdata_i = '0;
        set_upd(1'b0, 4'd0, 1'b0, 1'b0);
        test_reset();
        test_taken_inc();
        test_saturate();
        test_forwarding();
        test_drop();
        test_debug();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
